// File: rtl/translit_pkg.sv
// Shared constants and types for the transliteration sequencer: code width,
// reserved codes, arbiter state and the tag that follows each code through the mapper.
package translit_pkg;

  localparam int CODE_W = 7;

  localparam logic [CODE_W-1:0] WORD_END    = 7'b0000000;
  localparam logic [CODE_W-1:0] BUBBLE_CODE = 7'b1111111;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic src;
  } tag_t;

endpackage

// File: rtl/translit_sequencer_if.sv
// Requester, mapper and output handshake bundle of the transliteration sequencer.
// slave is the sequencer's view, master the view of whatever drives it.
interface translit_sequencer_if;
  import translit_pkg::*;

  logic              req0_valid;
  logic [CODE_W-1:0] req0_code;
  logic              req0_ready;
  logic              req1_valid;
  logic [CODE_W-1:0] req1_code;
  logic              req1_ready;
  logic [CODE_W-1:0] map_code;
  logic [CODE_W-1:0] map_result;
  logic              out_valid;
  logic [CODE_W-1:0] out_code;
  logic              out_src;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  req0_valid, req0_code, req1_valid, req1_code, map_result, out_ready,
    output req0_ready, req1_ready, map_code, out_valid, out_code, out_src, busy
  );

  modport master (
    output req0_valid, req0_code, req1_valid, req1_code, map_result, out_ready,
    input  req0_ready, req1_ready, map_code, out_valid, out_code, out_src, busy
  );

endinterface

// File: rtl/translit_result_fifo.sv
// Small synchronous FIFO holding {src, mapped code}; the head is read straight
// from registered storage and the occupancy is exported for credit accounting.
module translit_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop_i && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, so the head reads as zero out of reset
      // instead of whatever the array powered up with.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The upstream credit scheme must never push into a full FIFO without a pop.
  overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !do_pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/translit_sequencer.sv
// Word-granular round-robin arbiter sharing a fixed-latency, non-stallable code
// mapper between two requesters; results are re-tagged and buffered under credits.
module translit_sequencer
  import translit_pkg::*;
#(
  parameter int MAP_LATENCY = 5,
  parameter int CREDITS     = 4
) (
  input logic                 clock,
  input logic                 rst_n,
  translit_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int INF_W = $clog2(MAP_LATENCY + 2);

  state_e            state_q;
  logic              owner_q;
  logic              last_owner_q;
  logic [CODE_W-1:0] map_code_q;
  tag_t              issue_tag_q;
  tag_t              tag_pipe_q [MAP_LATENCY];

  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_ok;
  logic              want;
  logic              win_src;
  logic              accept;
  logic [CODE_W-1:0] acc_code;
  tag_t              tail;
  logic              pop;
  logic [CODE_W:0]   head;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave it holding its old value (which would infer a latch).
    want    = 1'b0;
    win_src = 1'b0;
    if (state_q == IDLE) begin
      want    = bus.req0_valid || bus.req1_valid;
      win_src = (bus.req0_valid && bus.req1_valid) ? ~last_owner_q : bus.req1_valid;
    end else begin
      want    = owner_q ? bus.req1_valid : bus.req0_valid;
      win_src = owner_q;
    end
  end

  // The issue register counts as in flight: it already holds a credit.
  always_comb begin
    inflight = INF_W'(issue_tag_q.valid);
    for (int i = 0; i < MAP_LATENCY; i++) inflight = inflight + INF_W'(tag_pipe_q[i].valid);
  end

  assign credit_ok = (32'(inflight) + 32'(fifo_count)) < CREDITS;
  assign accept    = want && credit_ok;
  assign acc_code  = win_src ? bus.req1_code : bus.req0_code;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      map_code_q   <= BUBBLE_CODE;
      issue_tag_q  <= '0;
      for (int i = 0; i < MAP_LATENCY; i++) tag_pipe_q[i] <= '0;
    end else begin
      map_code_q  <= accept ? acc_code : BUBBLE_CODE;
      issue_tag_q <= '{valid: accept, src: accept && win_src};
      tag_pipe_q[0] <= issue_tag_q;
      for (int i = 1; i < MAP_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];

      if (accept) begin
        if (state_q == IDLE) begin
          if (acc_code != WORD_END) begin
            state_q <= SERVE;
            owner_q <= win_src;
          end else begin
            last_owner_q <= win_src;
          end
        end else if (acc_code == WORD_END) begin
          state_q      <= IDLE;
          last_owner_q <= owner_q;
        end
      end
    end
  end

  // Tail of the tag pipe lines up with the mapper result for that code.
  assign tail = tag_pipe_q[MAP_LATENCY-1];
  assign pop  = (fifo_count != '0) && bus.out_ready;

  translit_result_fifo #(
    .DEPTH (CREDITS),
    .WIDTH (CODE_W + 1)
  ) u_fifo (
    .clk         (clock),
    .rst_n       (rst_n),
    .push_i      (tail.valid),
    .push_data_i ({tail.src, bus.map_result}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // Readies are forced low while reset is held, even if a requester is valid.
  assign bus.req0_ready = rst_n && accept && !win_src;
  assign bus.req1_ready = rst_n && accept && win_src;
  assign bus.map_code   = map_code_q;
  assign bus.out_valid  = fifo_count != '0;
  assign bus.out_src    = head[CODE_W];
  assign bus.out_code   = head[CODE_W-1:0];
  assign bus.busy       = (state_q == SERVE) || (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_translit_sequencer.sv
// Directed bench for translit_sequencer: an external mapper model, a
// queue-based behavioural model checked every cycle, and literal per-test expectations.
module tb_translit_sequencer;
  import translit_pkg::*;

  localparam int LAT  = 5;
  localparam int CRED = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  translit_sequencer_if bus ();

  translit_sequencer #(.MAP_LATENCY(LAT), .CREDITS(CRED)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int m_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, want, m_edge);
    end
  endtask

  // Hindi-to-English code table used by the mapper model.
  function automatic logic [CODE_W-1:0] map_fn(input logic [CODE_W-1:0] c);
    case (c)
      7'b1000000: return 7'b1000111;
      7'b0000001: return 7'b0010101;
      7'b0000000: return 7'b0000000;
      7'b1000010: return 7'b1000100;
      7'b1000011: return 7'b1011110;
      7'b1000101: return 7'b1100000;
      default:    return c ^ 7'b0101010;
    endcase
  endfunction

  // Mapper: fixed latency, never reset, never stalls.
  logic [CODE_W-1:0] mpipe [LAT];
  always @(posedge clock) begin
    mpipe[0] <= map_fn(bus.map_code);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.map_result = mpipe[LAT-1];

  // Requester drivers: each presents the head of its queue until accepted.
  logic [CODE_W-1:0] q0[$];
  logic [CODE_W-1:0] q1[$];
  bit acc0_seen = 1'b0;
  bit acc1_seen = 1'b0;

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_code  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_code  = '0;
    forever begin
      @(posedge clock); #1;
      if (rst_n && acc0_seen && q0.size() != 0) void'(q0.pop_front());
      if (rst_n && acc1_seen && q1.size() != 0) void'(q1.pop_front());
      bus.req0_valid = (q0.size() != 0);
      bus.req0_code  = (q0.size() != 0) ? q0[0] : '0;
      bus.req1_valid = (q1.size() != 0);
      bus.req1_code  = (q1.size() != 0) ? q1[0] : '0;
    end
  end

  // Behavioural model: accepted symbols wait LAT+1 edges, then join an ordered FIFO.
  typedef struct {
    int         due;
    logic [7:0] data;
  } item_t;

  item_t             iq[$];
  logic [7:0]        fq[$];
  int                m_owner = -1;
  bit                m_last  = 1'b1;
  logic [CODE_W-1:0] m_map_code = BUBBLE_CODE;

  bit                p_valid = 1'b0;
  int                p_win;
  logic [CODE_W-1:0] p_code;
  bit                p_pop;

  // Logs of what the DUT did, stamped with the edge count of the sampling cycle.
  int         gr_src[$];
  int         gr_cyc[$];
  logic [7:0] pop_d[$];
  int         pop_cyc[$];

  int  win;
  bit  credit;

  initial forever begin
    @(negedge clock);
    p_valid   = 1'b0;
    acc0_seen = 1'b0;
    acc1_seen = 1'b0;
    if (rst_n) begin
      credit = (iq.size() + fq.size()) < CRED;
      win = -1;
      if (m_owner < 0) begin
        if (bus.req0_valid && bus.req1_valid) win = m_last ? 0 : 1;
        else if (bus.req0_valid)              win = 0;
        else if (bus.req1_valid)              win = 1;
      end else if ((m_owner == 0) ? bus.req0_valid : bus.req1_valid) begin
        win = m_owner;
      end
      if (!credit) win = -1;

      check("req0_ready", bus.req0_ready, win == 0);
      check("req1_ready", bus.req1_ready, win == 1);
      check("out_valid", bus.out_valid, fq.size() != 0);
      if (fq.size() != 0) check("out_head", {bus.out_src, bus.out_code}, fq[0]);
      check("map_code", bus.map_code, m_map_code);
      check("busy", bus.busy, (m_owner >= 0) || (iq.size() != 0) || (fq.size() != 0));

      acc0_seen = bus.req0_valid && bus.req0_ready;
      acc1_seen = bus.req1_valid && bus.req1_ready;
      if (acc0_seen) begin gr_src.push_back(0); gr_cyc.push_back(m_edge); end
      if (acc1_seen) begin gr_src.push_back(1); gr_cyc.push_back(m_edge); end
      if (bus.out_valid && bus.out_ready) begin
        pop_d.push_back({bus.out_src, bus.out_code});
        pop_cyc.push_back(m_edge);
      end

      p_valid = 1'b1;
      p_win   = win;
      p_code  = (win == 1) ? bus.req1_code : bus.req0_code;
      p_pop   = (fq.size() != 0) && bus.out_ready;
    end
  end

  item_t it;
  initial forever begin
    @(posedge clock);
    m_edge++;
    if (!rst_n) begin
      iq.delete();
      fq.delete();
      m_owner    = -1;
      m_last     = 1'b1;
      m_map_code = BUBBLE_CODE;
    end else if (p_valid) begin
      if (p_pop && fq.size() != 0) void'(fq.pop_front());
      while (iq.size() != 0 && iq[0].due == m_edge) begin
        it = iq.pop_front();
        fq.push_back(it.data);
      end
      if (p_win >= 0) begin
        it.due  = m_edge + LAT + 1;
        it.data = {p_win[0], map_fn(p_code)};
        iq.push_back(it);
        m_map_code = p_code;
        if (m_owner < 0) begin
          if (p_code != WORD_END) m_owner = p_win;
          else                    m_last  = p_win[0];
        end else if (p_code == WORD_END) begin
          m_last  = m_owner[0];
          m_owner = -1;
        end
      end else begin
        m_map_code = BUBBLE_CODE;
      end
    end
  end

  // Stimulus helpers; all stimulus changes land 2 time units after a rising edge.
  task automatic sync();
    @(posedge clock); #2;
  endtask

  task automatic clear_logs();
    gr_src.delete(); gr_cyc.delete(); pop_d.delete(); pop_cyc.delete();
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    clear_logs();
    repeat (2) sync();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    sync();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction

  logic [7:0] want_pops[$];
  int         want_grants[$];

  task automatic check_pops(input string tag);
    check({tag, "_pop_count"}, pop_d.size(), want_pops.size());
    for (int i = 0; i < want_pops.size(); i++)
      check({tag, "_pop"}, (i < pop_d.size()) ? 32'(pop_d[i]) : 32'hDEAD, 32'(want_pops[i]));
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_grant_count"}, gr_src.size(), want_grants.size());
    for (int i = 0; i < want_grants.size(); i++)
      check({tag, "_grant"}, qget(gr_src, i), want_grants[i]);
  endtask

  int stale;

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("reset_map_code", bus.map_code, BUBBLE_CODE);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    sync();

    // Single word from req0.
    do_reset();
    q0 = {7'b1000000, 7'b0000001, 7'b0000000};
    repeat (20) sync();
    want_pops = {8'h47, 8'h15, 8'h00};
    check_pops("single");
    // Accept sampled in cycle k; out_valid first visible in cycle k+7.
    check("single_latency", qget(pop_cyc, 0) - qget(gr_cyc, 0), 7);
    check("single_busy_end", bus.busy, 0);

    // Word integrity with both requesters valid.
    do_reset();
    q0 = {7'b1000010, 7'b0000000};
    q1 = {7'b1000011, 7'b0000000};
    repeat (25) sync();
    want_grants = {0, 0, 1, 1};
    check_grants("word");
    want_pops = {8'h44, 8'h00, 8'hDE, 8'h80};
    check_pops("word");

    // Round robin on one-symbol words.
    do_reset();
    q0 = {7'b0000000, 7'b0000000, 7'b0000000};
    q1 = {7'b0000000, 7'b0000000, 7'b0000000};
    repeat (30) sync();
    want_grants = {0, 1, 0, 1, 0, 1};
    check_grants("rr");

    // Backpressure: credits run out, one pop buys exactly one more accept.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) q0.push_back(7'b0000010);
    repeat (20) sync();
    check("bp_accepts_stalled", gr_src.size(), 4);
    check("bp_no_ready", bus.req0_ready, 0);
    bus.out_ready = 1'b1;
    sync();
    bus.out_ready = 1'b0;
    repeat (12) sync();
    check("bp_accepts_after_pop", gr_src.size(), 5);
    check("bp_pops", pop_d.size(), 1);
    check("bp_credit_delay", qget(gr_cyc, 4) - qget(pop_cyc, 0), 1);

    // Reset with a word in progress and a result in flight.
    do_reset();
    q1 = {7'b1000101};
    for (int i = 0; i < 10 && gr_src.size() == 0; i++) sync();
    check("rst_first_accept", gr_src.size(), 1);
    repeat (2) sync();
    check("rst_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_map_code", bus.map_code, BUBBLE_CODE);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_code", bus.out_code, 0);
    check("rst_out_src", bus.out_src, 0);
    check("rst_busy", bus.busy, 0);
    q0.delete();
    q1.delete();
    clear_logs();
    repeat (2) sync();
    rst_n = 1'b1;
    sync();
    q0 = {7'b0000000};
    q1 = {7'b0000000};
    repeat (25) sync();
    want_grants = {0, 1};
    check_grants("rst_after");
    want_pops = {8'h00, 8'h80};
    check_pops("rst_after");
    stale = 0;
    foreach (pop_d[i]) if (pop_d[i][6:0] == 7'b1100000) stale++;
    check("rst_no_stale", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
